stepper_move_sequencer: RTL and testbench
=========================================

# stepper_move_sequencer

Command-level motion controller that drives one stepper driver channel. It accepts a move command: direction, step count, peak speed and ramp increment. It then sequences the driver's `speed`, `dir_in` and `run_en` inputs through a trapezoidal accelerate/cruise/decelerate profile, and counts the driver's `step` pulses to stop exactly on the commanded count. It sits between the top-level motion logic and the driver, so the top level only issues moves and waits for `done`.

## Interface
- `RAMP_TICK`, 250000: clock cycles between speed updates (10 ms at 25 MHz).
- `MIN_SPEED`, 10'd16: start/stop speed in steps/s. Also the floor for `cmd_vmax` and for deceleration.
- `clock` in 1: system clock, 25 MHz.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: move command valid.
- `cmd_ready` out 1: sequencer can accept a command; high only in IDLE.
- `cmd_dir` in 1: 1 = clockwise, 0 = counter-clockwise.
- `cmd_steps` in 24: microsteps to move; unsigned.
- `cmd_vmax` in 10: cruise speed in steps/s.
- `cmd_accel` in 8: speed change per `RAMP_TICK`.
- `abort` in 1: request a controlled stop; level, sampled each cycle.
- `step_in` in 1: driver `step` output, fed back to the sequencer.
- `speed` out 10: to driver `speed`.
- `dir_out` out 1: to driver `dir_in`.
- `run_en` out 1: to driver `run_en`.
- `busy` out 1: a move is in progress (ACCEL, CRUISE or DECEL).
- `done` out 1: one-cycle pulse at the end of a move.
- `aborted` out 1: valid with `done`; 1 if the move ended due to `abort`.
- `steps_done` out 24: rising edges of `step_in` counted in the current or last move; held until the next accept.

## Operation
- States: IDLE, ACCEL, CRUISE, DECEL, DONE.
- Step detect: register `step_q <= step_in`; `rise = step_in & ~step_q`. On `rise` during a move, in the same edge:
  - `remaining` decrements;
  - `steps_done` increments;
  - in ACCEL only, `ramp_steps` increments, saturating at 24'hFFFFFF.
- IDLE:
  - `cmd_ready` = 1; `run_en` = 0; `speed` = 0.
  - Accept on `cmd_valid & cmd_ready`. Latch `dir`, `remaining = cmd_steps`, `vmax = max(cmd_vmax, MIN_SPEED)`, `accel`.
  - On accept, clear `steps_done`, `ramp_steps` and the tick counter.
  - If `cmd_steps == 0`, go to DONE. Otherwise go to ACCEL with `speed = MIN_SPEED`.
- Tick counter: runs while busy. Wraps at `RAMP_TICK-1` and produces a one-cycle `tick`.
- ACCEL:
  - On `tick`: `speed = min(speed + accel, vmax)`, computed as an 11-bit sum.
  - Go to CRUISE when `speed == vmax`.
- CRUISE: `speed` holds at `vmax`.
- DECEL:
  - On `tick`: `speed = max(speed - accel, MIN_SPEED)`, computed signed / 11-bit.
- Deceleration trigger: checked every cycle in ACCEL and CRUISE. If `remaining <= ramp_steps`, go to DECEL. This takes priority over ACCEL→CRUISE.
- Completion: a `rise` with `remaining == 1` in any moving state goes to DONE. This takes priority over every other transition, including `abort`.
- Abort: `abort` high in ACCEL or CRUISE:
  - sets `remaining = min(remaining, ramp_steps)`, sets the internal abort flag, and goes to DECEL;
  - if the clamped value is 0, goes directly to DONE.
- `abort` is ignored in IDLE, DONE and DECEL; it still sets the flag if it arrives in DECEL.
- DONE (one cycle): `done` = 1, `aborted` = flag, `run_en` = 0, `speed` = 0. Then go to IDLE.
- `dir_out` is constant from accept to DONE. It keeps its last value in IDLE.
- `cmd_valid` while not ready is ignored; there is no queueing.

## Timing
- State after the reset edge: IDLE. Outputs: `cmd_ready` = 1; `speed`, `dir_out`, `run_en`, `busy`, `done`, `aborted`, `steps_done` all 0.
- Accept at edge N. From N+1: state ACCEL, `run_en` = 1, `speed = MIN_SPEED`, `busy` = 1, `cmd_ready` = 0.
- Final step rise sampled at edge M. From M+1: `run_en` = 0, `speed` = 0, `done` = 1, `steps_done == cmd_steps`. At M+2: IDLE, `cmd_ready` = 1.
  - The driver therefore sees `run_en` low before its current HIGH pulse completes, so it emits no extra step.
- Zero-step command: accept at N, `done` at N+1, IDLE at N+2. `run_en` never asserts.
- The first speed change occurs `RAMP_TICK` cycles after accept.
- Reset asserted mid-move: at the next edge, return to the reset state. `run_en` drops in that cycle. No `done` pulse.
- `speed` is never 0 while `run_en` = 1.

## Test plan
- `RAMP_TICK=100`, `MIN_SPEED=16`. Command steps=2000, vmax=400, accel=64:
  - speed sequence is 16, 80, 144, …, 400 then CRUISE;
  - DECEL entered when `remaining <= ramp_steps`;
  - exactly 2000 `step_in` rises, then `done` with `aborted` = 0 and `steps_done` = 2000.
- Short move, steps=10, vmax=1000: DECEL is entered before CRUISE is ever reached; exactly 10 steps; `speed` never drops below 16.
- steps=0: `done` one cycle after accept; `run_en` stays 0; IDLE two cycles after accept.
- Abort during CRUISE with `ramp_steps` = 50 and `remaining` = 900:
  - DECEL next cycle;
  - exactly 50 further steps;
  - `done` with `aborted` = 1.
- Abort and final step in the same cycle: DONE with `aborted` = 0 and `steps_done == cmd_steps`.
- Reset asserted mid-CRUISE: all outputs return to reset values the next cycle. A following command is accepted normally; `cmd_valid` pulses during a move are ignored.

Source files
------------

// File: rtl/stepper_move_sequencer.sv
// Move sequencer for one stepper driver channel: trapezoidal speed profile
// around a commanded step count, with step feedback counting and controlled abort.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a command, driver disabled
// ACCEL  | ramping speed up by accel each ramp tick, capped at vmax
// CRUISE | holding vmax until the remaining steps fit the ramp-down
// DECEL  | ramping speed down by accel each ramp tick, floored at MIN_SPEED
// DONE   | one-cycle completion pulse, driver disabled
module stepper_move_sequencer #(
    parameter int unsigned RAMP_TICK = 250000,
    parameter logic [9:0]  MIN_SPEED = 10'd16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_dir,
    input  logic [23:0] cmd_steps,
    input  logic [9:0]  cmd_vmax,
    input  logic [7:0]  cmd_accel,
    input  logic        abort,
    input  logic        step_in,
    output logic [9:0]  speed,
    output logic        dir_out,
    output logic        run_en,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [23:0] steps_done
);

    localparam int unsigned TICK_W = (RAMP_TICK > 1) ? $clog2(RAMP_TICK) : 1;
    localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(RAMP_TICK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEL,
        S_CRUISE,
        S_DECEL,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic              step_q;
    logic [23:0]       remaining, remaining_nxt;
    logic [23:0]       steps_done_q, steps_done_nxt;
    logic [23:0]       ramp_steps, ramp_steps_nxt;
    logic [TICK_W-1:0] tick_cnt, tick_cnt_nxt;
    logic [9:0]        vmax_q, vmax_nxt;
    logic [7:0]        accel_q, accel_nxt;
    logic              dir_q, dir_nxt;
    logic [9:0]        speed_q, speed_nxt;
    logic              abort_flag, abort_flag_nxt;

    logic              rise;
    logic              moving;
    logic              tick;
    logic [10:0]       accel_sum;
    logic [10:0]       decel_diff;
    logic [9:0]        accel_speed;
    logic [9:0]        decel_speed;
    logic [23:0]       rem_dec;
    logic [23:0]       rem_clamp;

    assign rise   = step_in & ~step_q;
    assign moving = (state == S_ACCEL) || (state == S_CRUISE) || (state == S_DECEL);
    assign tick   = moving && (tick_cnt == '0);

    // 11-bit arithmetic so neither the overshoot past vmax nor the undershoot
    // below zero can wrap before the clamp is applied.
    assign accel_sum   = {1'b0, speed_q} + {3'b000, accel_q};
    assign accel_speed = (accel_sum > {1'b0, vmax_q}) ? vmax_q : accel_sum[9:0];
    assign decel_diff  = {1'b0, speed_q} - {3'b000, accel_q};
    assign decel_speed = (decel_diff[10] || (decel_diff[9:0] < MIN_SPEED)) ? MIN_SPEED
                                                                           : decel_diff[9:0];

    assign rem_dec   = rise ? (remaining - 24'd1) : remaining;
    assign rem_clamp = (rem_dec < ramp_steps) ? rem_dec : ramp_steps;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            step_q       <= 1'b0;
            remaining    <= '0;
            steps_done_q <= '0;
            ramp_steps   <= '0;
            tick_cnt     <= '0;
            vmax_q       <= '0;
            accel_q      <= '0;
            dir_q        <= 1'b0;
            speed_q      <= '0;
            abort_flag   <= 1'b0;
        end else begin
            state        <= state_nxt;
            step_q       <= step_in;
            remaining    <= remaining_nxt;
            steps_done_q <= steps_done_nxt;
            ramp_steps   <= ramp_steps_nxt;
            tick_cnt     <= tick_cnt_nxt;
            vmax_q       <= vmax_nxt;
            accel_q      <= accel_nxt;
            dir_q        <= dir_nxt;
            speed_q      <= speed_nxt;
            abort_flag   <= abort_flag_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        remaining_nxt  = remaining;
        steps_done_nxt = steps_done_q;
        ramp_steps_nxt = ramp_steps;
        tick_cnt_nxt   = tick_cnt;
        vmax_nxt       = vmax_q;
        accel_nxt      = accel_q;
        dir_nxt        = dir_q;
        speed_nxt      = speed_q;
        abort_flag_nxt = abort_flag;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    dir_nxt        = cmd_dir;
                    remaining_nxt  = cmd_steps;
                    vmax_nxt       = (cmd_vmax < MIN_SPEED) ? MIN_SPEED : cmd_vmax;
                    accel_nxt      = cmd_accel;
                    steps_done_nxt = '0;
                    ramp_steps_nxt = '0;
                    tick_cnt_nxt   = TICK_LOAD;
                    abort_flag_nxt = 1'b0;
                    if (cmd_steps == 24'd0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ACCEL;
                        speed_nxt = MIN_SPEED;
                    end
                end
            end

            S_ACCEL, S_CRUISE, S_DECEL: begin
                tick_cnt_nxt = tick ? TICK_LOAD : (tick_cnt - TICK_W'(1));

                if (rise) begin
                    remaining_nxt  = rem_dec;
                    steps_done_nxt = steps_done_q + 24'd1;
                    if ((state == S_ACCEL) && (ramp_steps != 24'hFFFFFF))
                        ramp_steps_nxt = ramp_steps + 24'd1;
                end

                if (tick && (state == S_ACCEL))
                    speed_nxt = accel_speed;
                else if (tick && (state == S_DECEL))
                    speed_nxt = decel_speed;

                // The last step wins over everything, so an abort racing it
                // never marks a fully completed move as aborted.
                if (rise && (remaining == 24'd1)) begin
                    state_nxt = S_DONE;
                end else if (state == S_DECEL) begin
                    if (abort)
                        abort_flag_nxt = 1'b1;
                end else if (abort) begin
                    remaining_nxt  = rem_clamp;
                    abort_flag_nxt = 1'b1;
                    state_nxt      = (rem_clamp == 24'd0) ? S_DONE : S_DECEL;
                end else if (remaining <= ramp_steps) begin
                    state_nxt = S_DECEL;
                end else if ((state == S_ACCEL) && (speed_q == vmax_q)) begin
                    state_nxt = S_CRUISE;
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign cmd_ready  = (state == S_IDLE);
    assign busy       = moving;
    assign run_en     = moving;
    assign speed      = moving ? speed_q : 10'd0;
    assign dir_out    = dir_q;
    assign done       = (state == S_DONE);
    assign aborted    = (state == S_DONE) && abort_flag;
    assign steps_done = steps_done_q;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Directed bench for stepper_move_sequencer: completion results go through a
// scoreboard queue checked by a monitor on every done pulse.
module tb_stepper_move_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [23:0] cmd_steps;
    logic [9:0]  cmd_vmax;
    logic [7:0]  cmd_accel;
    logic        abort;
    logic        step_in;
    logic [9:0]  speed;
    logic        dir_out;
    logic        run_en;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [23:0] steps_done;

    stepper_move_sequencer #(
        .RAMP_TICK(100),
        .MIN_SPEED(10'd16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .cmd_vmax  (cmd_vmax),
        .cmd_accel (cmd_accel),
        .abort     (abort),
        .step_in   (step_in),
        .speed     (speed),
        .dir_out   (dir_out),
        .run_en    (run_en),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .steps_done(steps_done)
    );

    initial forever #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic        ab;
        logic [23:0] steps;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // completion monitor
    exp_t e;
    initial forever begin
        @(negedge clock);
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_aborted"}, 32'(aborted), 32'(e.ab));
                check({e.name, "_steps_done"}, 32'(steps_done), 32'(e.steps));
                check({e.name, "_run_en_at_done"}, 32'(run_en), 32'd0);
            end
        end
    end

    // speed monitor
    int         speed_viol = 0;
    logic [9:0] spd_max = '0;
    logic [9:0] spd_min = '1;
    logic       rec_en = 1'b0;
    logic [9:0] last_spd = '0;
    logic [9:0] spd_log[$];
    initial forever begin
        @(negedge clock);
        if (run_en === 1'b1) begin
            if (speed < 10'd16) speed_viol++;
            if (speed > spd_max) spd_max = speed;
            if (speed < spd_min) spd_min = speed;
            if (rec_en && (speed != last_spd)) begin
                spd_log.push_back(speed);
                last_spd = speed;
            end
        end
    end

    // driver step model: auto mode pulses 2 high / 2 low while run_en
    logic step_auto = 1'b1;
    logic manual_step = 1'b0;
    int   ph = 0;
    int   rise_cnt = 0;
    logic prev_step;
    initial begin
        step_in = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            prev_step = step_in;
            if (step_auto) begin
                if (run_en) begin
                    ph = (ph + 1) % 4;
                    step_in = (ph >= 2);
                end else begin
                    ph = 0;
                    step_in = 1'b0;
                end
            end else begin
                step_in = manual_step;
            end
            if (step_in && !prev_step) rise_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int k = 0;
        while (!cmd_ready && k < bound) begin
            cyc(1);
            k++;
        end
        check({name, "_idle_timeout"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic issue(input string name, input logic d, input int steps, input int vmax,
                         input int acc, input logic push, input logic ab_exp, input int steps_exp);
        exp_t x;
        wait_idle({name, "_pre"}, 50);
        if (push) begin
            x.name  = name;
            x.ab    = ab_exp;
            x.steps = 24'(steps_exp);
            sb_q.push_back(x);
        end
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_steps = 24'(steps);
        cmd_vmax  = 10'(vmax);
        cmd_accel = 8'(acc);
        cyc(1);
        cmd_valid = 1'b0;
    endtask

    task automatic mpulse(input int hi, input int lo);
        manual_step = 1'b1;
        cyc(hi);
        manual_step = 1'b0;
        cyc(lo);
    endtask

    logic [9:0] exp_seq[8];
    int r0;
    int k;

    initial begin
        exp_seq = '{10'd16, 10'd80, 10'd144, 10'd208, 10'd272, 10'd336, 10'd400, 10'd336};
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0; cmd_vmax = '0; cmd_accel = '0;
        abort = 1'b0;
        cyc(3);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_speed", 32'(speed), 32'd0);
        check("rst_run_en", 32'(run_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_steps_done", 32'(steps_done), 32'd0);
        reset = 1'b0;
        cyc(2);

        // full trapezoid
        rec_en = 1'b1; last_spd = '0; spd_log.delete();
        r0 = rise_cnt;
        issue("long", 1'b1, 2000, 400, 64, 1'b1, 1'b0, 2000);
        check("long_run_en", 32'(run_en), 32'd1);
        check("long_speed_start", 32'(speed), 32'd16);
        check("long_busy", 32'(busy), 32'd1);
        check("long_cmd_ready", 32'(cmd_ready), 32'd0);
        check("long_dir", 32'(dir_out), 32'd1);
        cyc(99);
        check("long_speed_pre_tick", 32'(speed), 32'd16);
        cyc(1);
        check("long_speed_first_tick", 32'(speed), 32'd80);
        wait_idle("long", 12000);
        rec_en = 1'b0;
        check("long_rises", 32'(rise_cnt - r0), 32'd2000);
        check("long_profile_len_ok", 32'(spd_log.size() >= 8), 32'd1);
        for (int i = 0; i < 8; i++)
            if (i < spd_log.size()) check($sformatf("long_profile_%0d", i), 32'(spd_log[i]), 32'(exp_seq[i]));

        // short move never reaches cruise
        spd_max = '0; spd_min = '1;
        r0 = rise_cnt;
        issue("short", 1'b0, 10, 1000, 64, 1'b1, 1'b0, 10);
        check("short_dir", 32'(dir_out), 32'd0);
        wait_idle("short", 500);
        check("short_rises", 32'(rise_cnt - r0), 32'd10);
        check("short_speed_max", 32'(spd_max), 32'd16);
        check("short_speed_min", 32'(spd_min), 32'd16);

        // zero-step command
        issue("zero", 1'b1, 0, 100, 10, 1'b1, 1'b0, 0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_run_en", 32'(run_en), 32'd0);
        check("zero_cmd_ready_n1", 32'(cmd_ready), 32'd0);
        cyc(1);
        check("zero_cmd_ready_n2", 32'(cmd_ready), 32'd1);
        check("zero_run_en_n2", 32'(run_en), 32'd0);
        check("zero_dir_held", 32'(dir_out), 32'd1);

        // abort in cruise with ramp_steps=50, remaining=900
        step_auto = 1'b0;
        issue("abort_cruise", 1'b1, 950, 20, 1, 1'b1, 1'b1, 100);
        repeat (50) mpulse(1, 1);
        cyc(350);
        check("abort_cruise_speed", 32'(speed), 32'd20);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("abort_cruise_still_busy", 32'(busy), 32'd1);
        spd_min = '1;
        r0 = rise_cnt;
        k = 0;
        while (busy && k < 80) begin
            mpulse(2, 2);
            k++;
        end
        check("abort_cruise_rises", 32'(rise_cnt - r0), 32'd50);
        check("abort_cruise_decel", 32'(spd_min < 10'd20), 32'd1);
        wait_idle("abort_cruise", 20);

        // abort coincident with the final step
        issue("abort_final", 1'b0, 3, 0, 5, 1'b1, 1'b0, 3);
        cyc(2);
        mpulse(1, 1);
        mpulse(1, 1);
        manual_step = 1'b1;
        abort = 1'b1;
        cyc(1);
        manual_step = 1'b0;
        abort = 1'b0;
        check("abort_final_done", 32'(done), 32'd1);
        check("abort_final_aborted", 32'(aborted), 32'd0);
        wait_idle("abort_final", 20);

        // abort with no ramp steps clamps to zero and finishes at once
        issue("abort_zero", 1'b1, 5, 0, 5, 1'b1, 1'b1, 0);
        cyc(2);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("abort_zero_done", 32'(done), 32'd1);
        wait_idle("abort_zero", 20);

        // reset mid-cruise, then a normal move ignoring extra cmd_valid
        step_auto = 1'b1;
        issue("reset_run", 1'b1, 5000, 0, 5, 1'b0, 1'b0, 0);
        cyc(40);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_speed", 32'(speed), 32'd0);
        check("midrst_dir", 32'(dir_out), 32'd0);
        check("midrst_run_en", 32'(run_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_steps_done", 32'(steps_done), 32'd0);
        cyc(2);
        r0 = rise_cnt;
        issue("after_reset", 1'b1, 20, 16, 5, 1'b1, 1'b0, 20);
        cyc(10);
        cmd_valid = 1'b1;
        cmd_steps = 24'd7;
        cyc(1);
        cmd_valid = 1'b0;
        check("after_reset_busy", 32'(busy), 32'd1);
        wait_idle("after_reset", 300);
        check("after_reset_rises", 32'(rise_cnt - r0), 32'd20);

        cyc(5);
        check("pending_expectations", 32'(sb_q.size()), 32'd0);
        check("speed_floor_violations", 32'(speed_viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
